// File: rtl/borrow_lookahead_subtractor_seq.sv
// Digit-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead digit per clock.
// Optional zero flag output is enabled by defining SUB_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand handshake
// RUN   | one digit per edge, LSB digit first, running borrow carried between digits
// DONE  | out_valid=1, result held until out_ready
module borrow_lookahead_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
`ifdef SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] d;
  logic [4:0] c;
  logic       last;

  // Borrow-lookahead slice: generate = ~A&B, propagate = ~(A^B), c[0] is the running borrow.
  always_comb begin
    a_dig = 4'(a_q >> (4 * cnt));
    b_dig = 4'(b_q >> (4 * cnt));
    g     = ~a_dig & b_dig;
    p     = ~(a_dig ^ b_dig);
    c[0]  = borrow;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    d     = a_dig ^ b_dig ^ c[3:0];
    last  = (cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef SUB_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            borrow   <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            zero     <= 1'b1;
`endif
            state    <= RUN;
          end
        end
        RUN: begin
          diff[4*cnt +: 4] <= d;
          borrow           <= c[4];
`ifdef SUB_ZERO_FLAG_EN
          zero             <= zero & (d == 4'h0);
`endif
          if (last) begin
            bout      <= c[4];
            ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d[3] ^ a_q[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_lookahead_subtractor_seq.sv
// Directed bench for borrow_lookahead_subtractor_seq (WIDTH=16); zero flag checked when SUB_ZERO_FLAG_EN is defined.
module tb_borrow_lookahead_subtractor_seq;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
`ifdef SUB_ZERO_FLAG_EN
  logic             zero;
`endif

  int n_vec = 0;
  int n_err = 0;

  borrow_lookahead_subtractor_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
`ifdef SUB_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction: accept, 4 RUN edges, check result, handshake out.
  task automatic do_sub(input string tag, input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                        input logic [15:0] ediff, input logic ebout, input logic eovf, input logic ezero);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
    check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " diff"}, 32'(diff), 32'(ediff));
    check({tag, " bout"}, 32'(bout), 32'(ebout));
    check({tag, " ovf"}, 32'(ovf), 32'(eovf));
`ifdef SUB_ZERO_FLAG_EN
    check({tag, " zero"}, 32'(zero), 32'(ezero));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst bout", 32'(bout), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
`ifdef SUB_ZERO_FLAG_EN
    check("rst zero", 32'(zero), 32'd0);
`endif
    rst_n = 1'b1;

    do_sub("v1234",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    do_sub("wrap",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_sub("equal",  16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    do_sub("bin1",   16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_sub("eqbin",  16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    do_sub("ovfneg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    do_sub("ovfpos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    do_sub("chain",  16'hA5C3, 16'h5A3C, 1'b0, 16'h4B87, 1'b0, 1'b1, 1'b0);

    // Backpressure, with a second request held from the first RUN cycle onward.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0010; b = 16'h0001; bin = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp diff", 32'(diff), 32'h1000);
      check("bp bout", 32'(bout), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second accepted", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp second early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp second valid", 32'(out_valid), 32'd1);
    check("bp second diff", 32'(diff), 32'h000F);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset on the second RUN edge discards the in-flight result.
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst in_ready", 32'(in_ready), 32'd1);
    check("mrst out_valid", 32'(out_valid), 32'd0);
    check("mrst diff", 32'(diff), 32'd0);
    check("mrst bout", 32'(bout), 32'd0);
    repeat (5) @(negedge clk);
    check("mrst stays idle", 32'(out_valid), 32'd0);
    do_sub("post", 16'h4321, 16'h1111, 1'b1, 16'h320F, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
